mem_sram: RTL and testbench

MEM_SRAM -- requirements
Module: mem_sram

---
 rtl/mem_sram.sv | 114 +++++++++++
 tb/tb_mem_sram.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_sram.sv
// Byte-addressable 32-bit big-endian SRAM with 1/2/4-byte loads and stores, 1-cycle load latency.
// Optional macro MEM_SRAM_ALIGN_CHECK_EN suppresses misaligned half/word accesses instead of force-aligning them.
module mem_sram #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [3:0]            width_i,
   input  logic [31:0]           data_i,
   output logic [31:0]           data_o,
   output logic                  err
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [31:0] data_mem [DEPTH_WORDS];

   logic [ADDR_WIDTH-3:0] w_word;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_legal;
   logic                  w_misalign;
   logic [1:0]            w_eoff;
   logic [3:0]            w_be;
   logic [31:0]           w_wdata;
   logic [31:0]           w_rword;
   logic [31:0]           w_rdata;
   logic                  w_ok;
   logic [31:0]           r_data;
   logic                  r_err;

   assign w_word  = addr_i[ADDR_WIDTH-1:2];
   assign w_idx   = IDX_W'(w_word % (ADDR_WIDTH-2)'(DEPTH_WORDS));
   assign w_legal = (width_i == 4'd1) || (width_i == 4'd2) || (width_i == 4'd4);

`ifdef MEM_SRAM_ALIGN_CHECK_EN
   assign w_misalign = ((width_i == 4'd2) && addr_i[0]) ||
                       ((width_i == 4'd4) && (addr_i[1:0] != 2'b00));
   assign w_eoff     = addr_i[1:0];
`else
   // Misaligned offsets are silently aligned down to the access width.
   assign w_misalign = 1'b0;
   assign w_eoff     = (width_i == 4'd4) ? 2'b00 :
                       (width_i == 4'd2) ? {addr_i[1], 1'b0} : addr_i[1:0];
`endif

   assign w_ok = ce && w_legal && !w_misalign;

   // Byte-enable bit 3 is byte offset 0 (bits 31:24), big-endian.
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = data_i;
      if (w_ok) begin
         case (width_i)
            4'd4: begin
               w_be    = 4'b1111;
               w_wdata = data_i;
            end
            4'd2: begin
               w_be    = w_eoff[1] ? 4'b0011 : 4'b1100;
               w_wdata = {2{data_i[15:0]}};
            end
            default: begin
               w_be    = 4'b1000 >> w_eoff;
               w_wdata = {4{data_i[7:0]}};
            end
         endcase
      end
   end

   assign w_rword = data_mem[w_idx];

   always_comb begin
      w_rdata = w_rword;
      case (width_i)
         4'd2:    w_rdata = w_eoff[1] ? {16'h0000, w_rword[15:0]} : {16'h0000, w_rword[31:16]};
         4'd1: begin
            case (w_eoff)
               2'd0:    w_rdata = {24'h000000, w_rword[31:24]};
               2'd1:    w_rdata = {24'h000000, w_rword[23:16]};
               2'd2:    w_rdata = {24'h000000, w_rword[15:8]};
               default: w_rdata = {24'h000000, w_rword[7:0]};
            endcase
         end
         default: w_rdata = w_rword;
      endcase
   end

   // Storage is never reset; writes are blocked while rst is high.
   always_ff @(posedge clk) begin
      if (!rst && w_ok && we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) data_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= 32'h0;
         r_err  <= 1'b0;
      end else if (ce) begin
         r_err <= !w_ok;
         if (w_ok && !we) r_data <= w_rdata;
      end
   end

   assign data_o = r_data;
   assign err    = r_err;

endmodule

// File: tb/tb_mem_sram.sv
// Directed bench for mem_sram: table of load/store vectors plus reset sequences.
// Builds with or without MEM_SRAM_ALIGN_CHECK_EN defined.
module tb_mem_sram;

   typedef struct {
      logic        ce;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  width;
      logic [31:0] wdata;
      logic [31:0] exp_d;
      logic        exp_e;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        ce;
   logic        we;
   logic [31:0] addr_i;
   logic [3:0]  width_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        err;

   int n_chk  = 0;
   int n_pass = 0;
   vec_t vq[$];

   mem_sram #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024)) dut (
      .clk     (clk),
      .rst     (rst),
      .ce      (ce),
      .we      (we),
      .addr_i  (addr_i),
      .width_i (width_i),
      .data_i  (data_i),
      .data_o  (data_o),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk_d(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: data_o=%08h expected %08h", name, act, exp);
   endtask

   task automatic chk_e(input string name, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: err=%0b expected %0b", name, act, exp);
   endtask

   task automatic access(input logic c, input logic w, input logic [31:0] a,
                         input logic [3:0] wd, input logic [31:0] d);
      ce = c; we = w; addr_i = a; width_i = wd; data_i = d;
      @(posedge clk);
      #1;
      ce = 1'b0; we = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ce = 1'b0; we = 1'b0; addr_i = '0; width_i = 4'd4; data_i = '0;
      dut.data_mem[1] = 32'h11223344;
      dut.data_mem[3] = 32'h00000000;

      // ce, we, addr, width, wdata, expected data_o, expected err
      vq.push_back('{1'b1, 1'b0, 32'd4,  4'd4, 32'h0, 32'h11223344, 1'b0});
      vq.push_back('{1'b1, 1'b0, 32'd4,  4'd2, 32'h0, 32'h00001122, 1'b0});
      vq.push_back('{1'b1, 1'b0, 32'd6,  4'd2, 32'h0, 32'h00003344, 1'b0});
      vq.push_back('{1'b1, 1'b0, 32'd4,  4'd1, 32'h0, 32'h00000011, 1'b0});
      vq.push_back('{1'b1, 1'b0, 32'd5,  4'd1, 32'h0, 32'h00000022, 1'b0});
      vq.push_back('{1'b1, 1'b0, 32'd6,  4'd1, 32'h0, 32'h00000033, 1'b0});
      vq.push_back('{1'b1, 1'b0, 32'd7,  4'd1, 32'h0, 32'h00000044, 1'b0});
      vq.push_back('{1'b1, 1'b1, 32'd8,  4'd4, 32'hdeadbeef, 32'h00000044, 1'b0});
      vq.push_back('{1'b1, 1'b0, 32'd8,  4'd4, 32'h0, 32'hdeadbeef, 1'b0});
      vq.push_back('{1'b1, 1'b1, 32'd12, 4'd2, 32'h0000dead, 32'hdeadbeef, 1'b0});
      vq.push_back('{1'b1, 1'b0, 32'd12, 4'd4, 32'h0, 32'hdead0000, 1'b0});
      vq.push_back('{1'b1, 1'b1, 32'd14, 4'd2, 32'h0000beef, 32'hdead0000, 1'b0});
      vq.push_back('{1'b1, 1'b0, 32'd12, 4'd4, 32'h0, 32'hdeadbeef, 1'b0});
      vq.push_back('{1'b1, 1'b1, 32'd16, 4'd1, 32'h000000de, 32'hdeadbeef, 1'b0});
      vq.push_back('{1'b1, 1'b1, 32'd17, 4'd1, 32'h000000ad, 32'hdeadbeef, 1'b0});
      vq.push_back('{1'b1, 1'b1, 32'd18, 4'd1, 32'h000000be, 32'hdeadbeef, 1'b0});
      vq.push_back('{1'b1, 1'b1, 32'd19, 4'd1, 32'h000000ef, 32'hdeadbeef, 1'b0});
      vq.push_back('{1'b1, 1'b0, 32'd4,  4'd1, 32'h0, 32'h00000011, 1'b0});
      vq.push_back('{1'b1, 1'b0, 32'd16, 4'd4, 32'h0, 32'hdeadbeef, 1'b0});
      vq.push_back('{1'b1, 1'b1, 32'd8,  4'd3, 32'h12345678, 32'hdeadbeef, 1'b1});
      vq.push_back('{1'b1, 1'b0, 32'd8,  4'd4, 32'h0, 32'hdeadbeef, 1'b0});
      vq.push_back('{1'b1, 1'b0, 32'd4,  4'd3, 32'h0, 32'hdeadbeef, 1'b1});
      vq.push_back('{1'b0, 1'b0, 32'd4,  4'd4, 32'h0, 32'hdeadbeef, 1'b1});
      vq.push_back('{1'b1, 1'b0, 32'd4100, 4'd4, 32'h0, 32'h11223344, 1'b0});
`ifdef MEM_SRAM_ALIGN_CHECK_EN
      vq.push_back('{1'b1, 1'b0, 32'd5,  4'd2, 32'h0, 32'h11223344, 1'b1});
      vq.push_back('{1'b1, 1'b0, 32'd7,  4'd4, 32'h0, 32'h11223344, 1'b1});
      vq.push_back('{1'b1, 1'b1, 32'd9,  4'd4, 32'h00000000, 32'h11223344, 1'b1});
`else
      vq.push_back('{1'b1, 1'b0, 32'd5,  4'd2, 32'h0, 32'h00001122, 1'b0});
      vq.push_back('{1'b1, 1'b0, 32'd7,  4'd4, 32'h0, 32'h11223344, 1'b0});
      vq.push_back('{1'b1, 1'b1, 32'd21, 4'd4, 32'hcafef00d, 32'h11223344, 1'b0});
      vq.push_back('{1'b1, 1'b0, 32'd20, 4'd4, 32'h0, 32'hcafef00d, 1'b0});
`endif
      vq.push_back('{1'b1, 1'b0, 32'd8,  4'd4, 32'h0, 32'hdeadbeef, 1'b0});

      repeat (2) @(posedge clk);
      #1;
      chk_d("reset_data", data_o, 32'h0);
      chk_e("reset_err", err, 1'b0);
      rst = 1'b0;

      foreach (vq[i]) begin
         access(vq[i].ce, vq[i].we, vq[i].addr, vq[i].width, vq[i].wdata);
         chk_d($sformatf("vec%0d_data", i), data_o, vq[i].exp_d);
         chk_e($sformatf("vec%0d_err", i), err, vq[i].exp_e);
      end

      // Async reset between edges: outputs clear at once, storage survives.
      access(1'b1, 1'b0, 32'd4, 4'd3, 32'h0);
      chk_d("pre_rst_data", data_o, 32'hdeadbeef);
      chk_e("pre_rst_err", err, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_d("async_rst_data", data_o, 32'h0);
      chk_e("async_rst_err", err, 1'b0);
      access(1'b1, 1'b1, 32'd8, 4'd4, 32'h00000000);
      access(1'b1, 1'b0, 32'd4, 4'd4, 32'h0);
      chk_d("in_rst_load_data", data_o, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      access(1'b1, 1'b0, 32'd8, 4'd4, 32'h0);
      chk_d("post_rst_blocked_store", data_o, 32'hdeadbeef);
      chk_e("post_rst_err", err, 1'b0);
      access(1'b1, 1'b0, 32'd4, 4'd4, 32'h0);
      chk_d("post_rst_kept", data_o, 32'h11223344);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
